// File: rtl/mux_rr_nx1_if.sv
// mux_rr_nx1_if: channel-side and output-side handshake bundle for mux_rr_nx1.
//   din / din_valid / din_ready     : N request channels, channel i at din[i*W +: W]
//   dout / dout_sel / dout_valid    : registered output word and its source channel
//   dout_ready                      : downstream accept
// Modports:
//   slave  - the multiplexer's view (serves the channels, drives the output)
//   master - the environment's view (drives requests, consumes the output)
interface mux_rr_nx1_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
);
  logic [N*W-1:0] din;
  logic [N-1:0]   din_valid;
  logic [N-1:0]   din_ready;
  logic [W-1:0]   dout;
  logic [SW-1:0]  dout_sel;
  logic           dout_valid;
  logic           dout_ready;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_sel, dout_valid
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_sel, dout_valid
  );
endinterface

// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-input, W-bit registered multiplexer with round-robin arbitration.
// Requesting channels are searched starting after the last granted index; the winner's word is
// loaded into the output register together with its channel index. One word per cycle.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : mux_rr_nx1_if.slave (din, din_valid, din_ready, dout, dout_sel, dout_valid,
//              dout_ready); interface must be built with the same N and W
//   xfer_cnt : 16-bit count of completed output transfers, wraps; present only when the
//              macro MUX_RR_CNT_EN is defined
module mux_rr_nx1 #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_nx1_if.slave        bus
`ifdef MUX_RR_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  localparam int unsigned SW = $clog2(N);

  logic [W-1:0]  dout_q,  dout_d;
  logic [SW-1:0] sel_q,   sel_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] ptr_q,   ptr_d;

  logic          ld;
  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] cand;
  logic [W-1:0]  gnt_data;
  logic [W-1:0]  din_arr [N];
  logic [N-1:0]  din_ready;

  // Output register can take a new word when empty or being drained this cycle.
  assign ld = !valid_q || bus.dout_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      din_arr[i] = bus.din[i*W +: W];
    end
  end

  // Search ptr+1, ptr+2, ... wrapping modulo N and ending at ptr; first requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = SW'((32'(ptr_q) + k) % N);
      if (!gnt_found && bus.din_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
        gnt_data  = din_arr[cand];
      end
    end
  end

  // Grant is suppressed while reset is asserted so no channel sees an accept it loses.
  always_comb begin
    din_ready = '0;
    if (!rst && ld && gnt_found) begin
      din_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    dout_d  = dout_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (ld) begin
      if (gnt_found) begin
        dout_d  = gnt_data;
        sel_d   = gnt_idx;
        valid_d = 1'b1;
        ptr_d   = gnt_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SW'(N - 1);  // channel 0 has priority after reset
    end else begin
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_sel   = sel_q;
  assign bus.dout_valid = valid_q;

`ifdef MUX_RR_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && bus.dout_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1: self-checking bench for mux_rr_nx1 (N=4, W=8).
// Directed scenarios followed by randomized traffic, all compared against a behavioural model
// of the round-robin funnel kept in this file.
module tb_mux_rr_nx1;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  mux_rr_nx1_if #(.N(N), .W(W)) bus ();

`ifdef MUX_RR_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  mux_rr_nx1 #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef MUX_RR_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  int           m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First requester after the last winner, wrapping around all N channels.
  function automatic void model_grant(input logic [N-1:0] v, output bit found, output int g);
    found = 0;
    g     = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!found && v[c]) begin
        found = 1;
        g     = c;
      end
    end
  endfunction

  // One clock: apply inputs after the falling edge, check accept, step model, check outputs.
  task automatic step(input logic r, input logic [N-1:0] v, input logic dr,
                      input logic [N*W-1:0] d);
    bit             found;
    int             g;
    bit             ld;
    logic [N-1:0]   exp_ready;
    rst           = r;
    bus.din_valid = v;
    bus.dout_ready = dr;
    bus.din       = d;
    #1;
    model_grant(v, found, g);
    ld        = !m_valid || dr;
    exp_ready = '0;
    if (!r && ld && found) exp_ready[g] = 1'b1;
    check_eq("din_ready", 32'(bus.din_ready), 32'(exp_ready));
    @(posedge clk);
    if (r) begin
      m_valid = 0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = N - 1;
      m_cnt   = 0;
    end else begin
      if (m_valid && dr) m_cnt = (m_cnt + 1) % 65536;
      if (ld) begin
        if (found) begin
          m_valid = 1;
          m_data  = d[g*W +: W];
          m_sel   = g;
          m_ptr   = g;
        end else begin
          m_valid = 0;
        end
      end
    end
    @(negedge clk);
    check_eq("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
    check_eq("dout", 32'(bus.dout), 32'(m_data));
    check_eq("dout_sel", 32'(bus.dout_sel), 32'(m_sel));
`ifdef MUX_RR_CNT_EN
    check_eq("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
  endtask

  logic [N*W-1:0] dd;
  logic [N-1:0]   all;

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = '0;
    bus.dout_ready = 1'b0;
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = N - 1;
    m_cnt   = 0;
    dd  = 32'h4433_2211;
    all = 4'hF;
    @(negedge clk);

    // Reset held two cycles with every channel requesting.
    step(1'b1, all, 1'b1, dd);
    step(1'b1, all, 1'b1, dd);
    check_eq("rst_valid", 32'(bus.dout_valid), 32'd0);
    check_eq("rst_dout", 32'(bus.dout), 32'd0);

    // All channels requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, all, 1'b1, dd);
      check_eq("rr_sel", 32'(bus.dout_sel), 32'(i % 4));
      check_eq("rr_dout", 32'(bus.dout), 32'(8'h11 * (i % 4 + 1)));
    end

    // Stall with 8'h22 on the output.
    step(1'b0, all, 1'b1, dd);
    check_eq("stall_load", 32'(bus.dout), 32'h22);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, all, 1'b0, dd);
      check_eq("stall_hold", 32'(bus.dout), 32'h22);
    end
    step(1'b0, all, 1'b1, dd);
    check_eq("stall_next", 32'(bus.dout_sel), 32'd2);

    // Sparse requests after a grant to channel 0.
    step(1'b0, all, 1'b1, dd);
    step(1'b0, all, 1'b1, dd);
    check_eq("sparse_pre", 32'(bus.dout_sel), 32'd0);
    step(1'b0, 4'b1001, 1'b1, dd);
    check_eq("sparse_3", 32'(bus.dout_sel), 32'd3);
    step(1'b0, 4'b1001, 1'b1, dd);
    check_eq("sparse_0", 32'(bus.dout_sel), 32'd0);
    step(1'b0, 4'b0000, 1'b1, dd);
    check_eq("drain", 32'(bus.dout_valid), 32'd0);

    // Reset while a word is pending.
    step(1'b0, all, 1'b1, dd);
    check_eq("mid_pre", 32'(bus.dout_valid), 32'd1);
    step(1'b1, all, 1'b0, dd);
    check_eq("mid_rst", 32'(bus.dout_valid), 32'd0);
    step(1'b0, all, 1'b1, dd);
    check_eq("mid_after", 32'(bus.dout_sel), 32'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
           (N*W)'($urandom));
    end

`ifdef MUX_RR_CNT_EN
    step(1'b1, '0, 1'b0, dd);
    for (int i = 0; i < 11; i++) step(1'b0, all, 1'b1, dd);
    check_eq("cnt_10", 32'(xfer_cnt), 32'd10);
    for (int i = 0; i < 65536; i++) step(1'b0, all, 1'b1, (N*W)'($urandom));
    check_eq("cnt_wrap", 32'(xfer_cnt), 32'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
